// File: rtl/data_ram_lsu.sv
// Word-organised data RAM with byte/half/word load-store front end and fixed response latency.
// Optional misalignment trapping: define DATA_RAM_MISALIGN_CHECK_EN.
module data_ram_lsu #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [31:0] adr,
    input  logic [31:0] wr_data,
    output logic        ready,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rd_data,
    output logic        err
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned ADR_W = IDX_W + 2;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               accept;

    logic               we_q;
    logic [2:0]         size_q;
    logic [ADR_W-1:0]   adr_q;

    logic               a_we;
    logic [2:0]         a_size;
    logic [ADR_W-1:0]   a_adr;
    logic [IDX_W-1:0]   a_idx;

    logic               legal, misal, bad;
    logic [1:0]         off, off_eff;
    logic [3:0]         be;
    logic [31:0]        wdata_rep, word_rd, shifted, ld_val;

    logic [31:0]        mem [DEPTH];

    logic               unused_adr_hi;
    assign unused_adr_hi = ^adr[31:ADR_W];

    assign stall  = req & ~rsp_valid;
    assign accept = (state == IDLE) && req;

    // In IDLE the live request is being accepted; later states work on the latched copy.
    assign a_we   = (state == IDLE) ? we : we_q;
    assign a_size = (state == IDLE) ? size : size_q;
    assign a_adr  = (state == IDLE) ? adr[ADR_W-1:0] : adr_q;
    assign a_idx  = a_adr[ADR_W-1:2];

    // Access decode: legality, effective lane offset, byte enables and load extension.
    always_comb begin
        legal     = (a_size == 3'b000) || (a_size == 3'b001) || (a_size == 3'b010) ||
                    (a_size == 3'b100) || (a_size == 3'b101);
        off       = a_adr[1:0];
        off_eff   = off;
        misal     = 1'b0;
`ifdef DATA_RAM_MISALIGN_CHECK_EN
        misal     = ((a_size[1:0] == 2'b01) && off[0]) ||
                    ((a_size[1:0] == 2'b10) && (off != 2'b00));
`else
        if (a_size[1:0] == 2'b01) off_eff = {off[1], 1'b0};
        if (a_size[1:0] == 2'b10) off_eff = 2'b00;
`endif
        bad       = ~legal | misal;

        be        = 4'b1111;
        wdata_rep = wr_data;
        case (a_size[1:0])
            2'b00: begin
                be        = 4'b0001 << off_eff;
                wdata_rep = {4{wr_data[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << off_eff;
                wdata_rep = {2{wr_data[15:0]}};
            end
            default: ;
        endcase

        word_rd = mem[a_idx];
        shifted = word_rd >> {off_eff, 3'b000};
        case (a_size)
            3'b000:  ld_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  ld_val = word_rd;
            3'b100:  ld_val = {24'h000000, shifted[7:0]};
            3'b101:  ld_val = {16'h0000, shifted[15:0]};
            default: ld_val = 32'h0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) state_nxt = RESP;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ready     <= 1'b1;
            rsp_valid <= 1'b0;
            rd_data   <= 32'h0;
            err       <= 1'b0;
            we_q      <= 1'b0;
            size_q    <= 3'b000;
            adr_q     <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ready     <= (state_nxt == IDLE);
            rsp_valid <= (state_nxt == RESP);
            if (accept) begin
                we_q   <= we;
                size_q <= size;
                adr_q  <= adr[ADR_W-1:0];
            end
            // Synchronous read into the result register on the edge that enters RESP.
            if (state_nxt == RESP) begin
                rd_data <= (bad || a_we) ? 32'h0 : ld_val;
                err     <= bad;
            end
        end
    end

    // Store commits on the acceptance edge; memory itself is not reset.
    always_ff @(posedge clk) begin
        if (rst_n && accept && a_we && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[a_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_ram_lsu.sv
// Randomised and directed bench for data_ram_lsu at LATENCY 1, 3 and 4 against a byte-array model.
module tb_data_ram_lsu;
    localparam int DEPTH = 256;
    localparam int NBYTE = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst_n     [3];
    logic        req       [3];
    logic        we        [3];
    logic [2:0]  size      [3];
    logic [31:0] adr       [3];
    logic [31:0] wr_data   [3];
    logic        ready     [3];
    logic        stall     [3];
    logic        rsp_valid [3];
    logic [31:0] rd_data   [3];
    logic        err       [3];

    logic [7:0]  ref_mem [3][NBYTE];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    data_ram_lsu #(.DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .we(we[0]), .size(size[0]), .adr(adr[0]),
        .wr_data(wr_data[0]), .ready(ready[0]), .stall(stall[0]), .rsp_valid(rsp_valid[0]),
        .rd_data(rd_data[0]), .err(err[0]));
    data_ram_lsu #(.DEPTH(DEPTH), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .we(we[1]), .size(size[1]), .adr(adr[1]),
        .wr_data(wr_data[1]), .ready(ready[1]), .stall(stall[1]), .rsp_valid(rsp_valid[1]),
        .rd_data(rd_data[1]), .err(err[1]));
    data_ram_lsu #(.DEPTH(DEPTH), .LATENCY(4)) u_lat4 (
        .clk(clk), .rst_n(rst_n[2]), .req(req[2]), .we(we[2]), .size(size[2]), .adr(adr[2]),
        .wr_data(wr_data[2]), .ready(ready[2]), .stall(stall[2]), .rsp_valid(rsp_valid[2]),
        .rd_data(rd_data[2]), .err(err[2]));

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte-addressed reference: little-endian bytes, address wraps modulo the RAM size.
    task automatic model(input int d, input logic w, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] exp_rd, output logic exp_err);
        int unsigned ba, nb;
        logic        legal, mis;
        logic [31:0] v;
        ba    = a % NBYTE;
        legal = (sz == 3'b000) || (sz == 3'b001) || (sz == 3'b010) || (sz == 3'b100) || (sz == 3'b101);
        nb    = (sz[1:0] == 2'b00) ? 1 : ((sz[1:0] == 2'b01) ? 2 : 4);
        mis   = 1'b0;
`ifdef DATA_RAM_MISALIGN_CHECK_EN
        mis   = (ba % nb) != 0;
`else
        ba    = ba - (ba % nb);
`endif
        exp_err = !legal || mis;
        exp_rd  = 32'h0;
        if (!exp_err) begin
            if (w) begin
                for (int k = 0; k < int'(nb); k++) ref_mem[d][ba + k] = wd[8*k +: 8];
            end else begin
                v = 32'h0;
                for (int k = 0; k < int'(nb); k++) v = v | (32'(ref_mem[d][ba + k]) << (8 * k));
                if (!sz[2] && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
                if (!sz[2] && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
                exp_rd = v;
            end
        end
    endtask

    // One full handshake on DUT d, checked for latency, busy window, pulse width, err and load data.
    task automatic run(input int d, input logic w, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd_o, output logic er_o);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n, busy;
        bit          seen;
        model(d, w, sz, a, wd, exp_rd, exp_err);
        @(negedge clk);
        n = 0;
        while (!ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_idle", 32'(ready[d]), 32'd1);
        req[d] = 1'b1; we[d] = w; size[d] = sz; adr[d] = a; wr_data[d] = wd;
        #1;
        check("stall_accept", 32'(stall[d]), 32'd1);
        @(posedge clk);
        n = 0; busy = 0; seen = 0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            if (!ready[d]) busy++;
            if (rsp_valid[d]) seen = 1;
        end
        check("latency", 32'(n), 32'(lat_of(d)));
        check("busy_cycles", 32'(busy), 32'(lat_of(d)));
        rd_o = rd_data[d];
        er_o = err[d];
        req[d] = 1'b0;
        check("err", 32'(er_o), 32'(exp_err));
        if (!w) check("rd_data", rd_o, exp_rd);
        @(negedge clk);
        check("pulse_1cyc", 32'(rsp_valid[d]), 32'd0);
        check("rd_hold", rd_data[d], rd_o);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        int          n;
        bit          seen;
        logic [2:0]  sz;
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; size[d] = 3'b000;
            adr[d] = 32'h0; wr_data[d] = 32'h0;
        end

        // Reset behaviour, stall follows req during reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_ready", 32'(ready[d]), 32'd1);
            check("rst_rsp", 32'(rsp_valid[d]), 32'd0);
            check("rst_rd", rd_data[d], 32'h0);
            check("rst_err", 32'(err[d]), 32'd0);
        end
        req[0] = 1'b1;
        #1;
        check("rst_stall", 32'(stall[0]), 32'd1);
        req[0] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

        // Populate every word so model and RAM agree everywhere.
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < DEPTH; i++) run(d, 1'b1, 3'b010, 32'(4 * i), $urandom, r, e);

        // Word store and load.
        run(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, r, e);
        run(0, 1'b0, 3'b010, 32'h10, 32'h0, r, e);
        check("dir_word", r, 32'hDEADBEEF);

        // Partial stores and extension.
        run(0, 1'b1, 3'b010, 32'h20, 32'h0, r, e);
        run(0, 1'b1, 3'b000, 32'h23, 32'h80, r, e);
        run(0, 1'b1, 3'b001, 32'h20, 32'h8001, r, e);
        run(0, 1'b0, 3'b010, 32'h20, 32'h0, r, e);  check("dir_lw", r, 32'h80008001);
        run(0, 1'b0, 3'b000, 32'h23, 32'h0, r, e);  check("dir_lb", r, 32'hFFFFFF80);
        run(0, 1'b0, 3'b100, 32'h23, 32'h0, r, e);  check("dir_lbu", r, 32'h00000080);
        run(0, 1'b0, 3'b001, 32'h20, 32'h0, r, e);  check("dir_lh", r, 32'hFFFF8001);
        run(0, 1'b0, 3'b101, 32'h20, 32'h0, r, e);  check("dir_lhu", r, 32'h00008001);

        // LATENCY=3 with address wrap.
        run(1, 1'b1, 3'b010, 32'h4, 32'h12345678, r, e);
        run(1, 1'b0, 3'b010, 32'h404, 32'h0, r, e);
        check("wrap_load", r, 32'h12345678);

        // Misalignment and illegal size.
        run(0, 1'b1, 3'b010, 32'h30, 32'h11223344, r, e);
        run(0, 1'b1, 3'b001, 32'h31, 32'h5566, r, e);
`ifdef DATA_RAM_MISALIGN_CHECK_EN
        check("mis_err", 32'(e), 32'd1);
        run(0, 1'b0, 3'b010, 32'h30, 32'h0, r, e);
        check("mis_word", r, 32'h11223344);
`else
        check("mis_err", 32'(e), 32'd0);
        run(0, 1'b0, 3'b010, 32'h30, 32'h0, r, e);
        check("mis_word", r, 32'h11225566);
`endif
        run(0, 1'b1, 3'b011, 32'h30, 32'hFFFFFFFF, r, e);
        check("ill_st_err", 32'(e), 32'd1);
        run(0, 1'b0, 3'b111, 32'h30, 32'h0, r, e);
        check("ill_ld_err", 32'(e), 32'd1);
        check("ill_ld_rd", r, 32'h0);

        // Reset two cycles after a LATENCY=4 store: no response, store persists.
        model(2, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, r, e);
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b1; size[2] = 3'b010; adr[2] = 32'h40; wr_data[2] = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n[2] = 1'b0;
        req[2] = 1'b0;
        @(negedge clk);
        rst_n[2] = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid[2]) seen = 1;
        end
        check("rst_mid_norsp", 32'(seen), 32'd0);
        check("rst_mid_ready", 32'(ready[2]), 32'd1);
        run(2, 1'b0, 3'b010, 32'h40, 32'h0, r, e);
        check("rst_mid_store", r, 32'hCAFEF00D);

        // Random traffic on every latency.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 150; i++) begin
                sz = 3'($urandom_range(0, 7));
                run(d, 1'($urandom_range(0, 1)), sz, $urandom, $urandom, r, e);
            end
        end

        n = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
